bus_arbiter: RTL

Round-robin arbiter sharing one bus slave (memory side of `bus_if`) among `NUM_MASTERS` requesters. It sits between the CPU/DMA master ports and the single memory slave port and serialises transactions with registered slave-side outputs. It reports the in-flight transaction type as `bus_transaction_t`. An optional timeout aborts hung slave accesses.

---
 rtl/bus_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 29 ++
 rtl/bus_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types for the round-robin bus arbiter: FSM states, transaction status
// reported to the system, and the wait-counter width.
package bus_arb_pkg;

   localparam int unsigned TIMEOUT_W = 10;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_RESP
   } arb_state_t;

   typedef enum logic [1:0] {
      BUS_IDLE,
      BUS_READ,
      BUS_WRITE,
      BUS_ERROR
   } bus_transaction_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// scanning upward with wrap-around.
module rr_pick #(
   parameter int unsigned NUM_MASTERS = 4
) (
   input  logic [NUM_MASTERS-1:0]         req,
   input  logic [$clog2(NUM_MASTERS)-1:0] ptr,
   output logic                           grant_valid,
   output logic [$clog2(NUM_MASTERS)-1:0] grant_idx
);

   localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

   int unsigned cand;

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         cand = (int'(ptr) + i) % NUM_MASTERS;
         if (!grant_valid && req[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter serialising NUM_MASTERS requesters onto one bus slave.
// Optional slave-wait timeout is enabled with `define BUS_ARB_TIMEOUT_EN.
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int unsigned NUM_MASTERS    = 4,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_MASTERS-1:0]            m_req,
   input  logic [NUM_MASTERS-1:0]            m_we,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
   output logic [NUM_MASTERS-1:0]            m_ack,
   output logic                              m_err,
   output logic [DATA_WIDTH-1:0]             m_rdata,
   output logic                              s_req,
   output logic                              s_we,
   output logic                              s_valid,
   output logic [ADDR_WIDTH-1:0]             s_addr,
   output logic [DATA_WIDTH-1:0]             s_wdata,
   input  logic                              s_ack,
   input  logic [DATA_WIDTH-1:0]             s_rdata,
   output logic [$clog2(NUM_MASTERS)-1:0]    grant_idx,
   output bus_transaction_t                  cur_txn
);

   localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

   if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023)
   begin : g_bad_cfg
      $error("bus_arbiter: parameter out of legal range");
   end

   arb_state_t             state_q,   state_d;
   bus_transaction_t       cur_txn_q, cur_txn_d;
   logic [IDX_W-1:0]       ptr_q,     ptr_d;
   logic [IDX_W-1:0]       grant_q,   grant_d;
   logic                   s_req_q,   s_req_d;
   logic                   s_we_q,    s_we_d;
   logic [ADDR_WIDTH-1:0]  s_addr_q,  s_addr_d;
   logic [DATA_WIDTH-1:0]  s_wdata_q, s_wdata_d;
   logic [NUM_MASTERS-1:0] m_ack_q,   m_ack_d;
   logic [DATA_WIDTH-1:0]  m_rdata_q, m_rdata_d;
`ifdef BUS_ARB_TIMEOUT_EN
   logic                   m_err_q,   m_err_d;
   logic [TIMEOUT_W-1:0]   wait_q,    wait_d;
`endif

   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;

   rr_pick #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_rr_pick (
      .req         (m_req),
      .ptr         (ptr_q),
      .grant_valid (pick_valid),
      .grant_idx   (pick_idx)
   );

   always_comb begin
      state_d   = state_q;
      cur_txn_d = cur_txn_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      s_req_d   = s_req_q;
      s_we_d    = s_we_q;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      m_ack_d   = '0;
      m_rdata_d = m_rdata_q;
`ifdef BUS_ARB_TIMEOUT_EN
      m_err_d   = 1'b0;
      wait_d    = wait_q;
`endif
      unique case (state_q)
         ARB_IDLE: begin
            cur_txn_d = BUS_IDLE;
            if (pick_valid) begin
               grant_d   = pick_idx;
               s_req_d   = 1'b1;
               s_we_d    = m_we[pick_idx];
               s_addr_d  = m_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
               s_wdata_d = m_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
               cur_txn_d = m_we[pick_idx] ? BUS_WRITE : BUS_READ;
               state_d   = ARB_ISSUE;
`ifdef BUS_ARB_TIMEOUT_EN
               wait_d    = '0;
`endif
            end
         end
         ARB_ISSUE: begin
            // ack takes priority over a timeout landing on the same cycle
            if (s_ack) begin
               s_req_d          = 1'b0;
               m_ack_d[grant_q] = 1'b1;
               m_rdata_d        = s_we_q ? '0 : s_rdata;
               state_d          = ARB_RESP;
            end
`ifdef BUS_ARB_TIMEOUT_EN
            else if (wait_q == TIMEOUT_W'(TIMEOUT_CYCLES)) begin
               s_req_d          = 1'b0;
               m_ack_d[grant_q] = 1'b1;
               m_err_d          = 1'b1;
               m_rdata_d        = '0;
               cur_txn_d        = BUS_ERROR;
               state_d          = ARB_RESP;
            end else begin
               wait_d = wait_q + 1'b1;
            end
`endif
         end
         ARB_RESP: begin
            ptr_d     = (grant_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
            cur_txn_d = BUS_IDLE;
            state_d   = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ARB_IDLE;
         cur_txn_q <= BUS_IDLE;
         ptr_q     <= '0;
         grant_q   <= '0;
         s_req_q   <= 1'b0;
         s_we_q    <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         m_ack_q   <= '0;
         m_rdata_q <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
         m_err_q   <= 1'b0;
         wait_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cur_txn_q <= cur_txn_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         s_req_q   <= s_req_d;
         s_we_q    <= s_we_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         m_ack_q   <= m_ack_d;
         m_rdata_q <= m_rdata_d;
`ifdef BUS_ARB_TIMEOUT_EN
         m_err_q   <= m_err_d;
         wait_q    <= wait_d;
`endif
      end
   end

   assign m_ack     = m_ack_q;
   assign m_rdata   = m_rdata_q;
   assign s_req     = s_req_q;
   assign s_valid   = s_req_q;
   assign s_we      = s_we_q;
   assign s_addr    = s_addr_q;
   assign s_wdata   = s_wdata_q;
   assign grant_idx = grant_q;
   assign cur_txn   = cur_txn_q;
`ifdef BUS_ARB_TIMEOUT_EN
   assign m_err     = m_err_q;
`else
   assign m_err     = 1'b0;
`endif

endmodule
